// File: rtl/voq_pkg.sv
// Shared FSM state type and address/counter width helpers for the linked-list VOQ buffer.
package voq_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } voq_state_e;

  function automatic int aw_f(input int depth);
    return $clog2(depth);
  endfunction

  // Counters need one extra bit so a completely full (or free) store is representable.
  function automatic int cw_f(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/voq_ll_buf_ram.sv
// Simple dual-port payload store: one write port, one registered read port.
// Read data appears the cycle after rd_en_i and holds until the next read.
module voq_ll_buf_ram #(
  parameter int DW    = 128,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)       rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/voq_ll_buf.sv
// Per-queue linked lists sharing one cell store; dequeued data is valid one cycle after rd_ack.
// Writes stall (wr_ready low) on an empty free list or a queue at quota; reads never stall.
module voq_ll_buf
  import voq_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 64,
  parameter int QUEUE_NUB  = 4,
  parameter int QUOTA      = 32,
  localparam int AW = aw_f(DEPTH),
  localparam int QW = $clog2(QUEUE_NUB),
  localparam int CW = cw_f(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [QW-1:0]           wr_client,
  input  logic                    rd_req,
  input  logic [QW-1:0]           rd_client,
  output logic                    rd_ack,
  output logic                    rd_valid,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic [QUEUE_NUB-1:0]    queue_empty,
  output logic [QUEUE_NUB*CW-1:0] queue_cnt,
  output logic [CW-1:0]           free_cnt,
  output logic                    init_done
);

  voq_state_e    state_q;
  logic [AW-1:0] init_cnt_q;
  logic          init_done_q;

  logic [AW-1:0] fl_mem [DEPTH];
  logic [AW-1:0] fl_rd_q, fl_rd_d;
  logic [AW-1:0] fl_wr_q, fl_wr_d;
  logic [CW-1:0] free_cnt_q, free_cnt_d;

  logic [AW-1:0] nxt_mem [DEPTH];
  logic [AW-1:0] head_q [QUEUE_NUB];
  logic [AW-1:0] head_d [QUEUE_NUB];
  logic [AW-1:0] tail_q [QUEUE_NUB];
  logic [AW-1:0] tail_d [QUEUE_NUB];
  logic [CW-1:0] cnt_q  [QUEUE_NUB];
  logic [CW-1:0] cnt_d  [QUEUE_NUB];
  logic          rd_valid_q;

  logic                 run;
  logic                 wr_client_ok;
  logic                 rd_client_ok;
  logic                 wr_fire;
  logic                 fl_push;
  logic [AW-1:0]        fl_push_addr;
  logic [AW-1:0]        wr_addr;
  logic [AW-1:0]        rd_addr;
  logic [QUEUE_NUB-1:0] wr_hit;
  logic [QUEUE_NUB-1:0] rd_hit;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign run          = (state_q == RUN);
  assign wr_client_ok = 32'(wr_client) < QUEUE_NUB;
  assign rd_client_ok = 32'(rd_client) < QUEUE_NUB;

  // Admission uses only registered occupancy, so a cell freed this cycle is usable next cycle.
  assign wr_ready = run && (free_cnt_q != '0) && wr_client_ok &&
                    (32'(cnt_q[wr_client]) < QUOTA);
  assign wr_fire  = wr_valid && wr_ready;
  assign rd_ack   = rd_req && run && rd_client_ok && (cnt_q[rd_client] != '0);

  assign wr_addr      = fl_mem[fl_rd_q];
  assign rd_addr      = head_q[rd_client];
  assign fl_push      = !run || rd_ack;
  assign fl_push_addr = run ? rd_addr : init_cnt_q;

  always_comb begin
    wr_hit = '0;
    rd_hit = '0;
    if (wr_fire) wr_hit[wr_client] = 1'b1;
    if (rd_ack)  rd_hit[rd_client] = 1'b1;
  end

  always_comb begin
    fl_rd_d    = wr_fire ? ptr_inc(fl_rd_q) : fl_rd_q;
    fl_wr_d    = fl_push ? ptr_inc(fl_wr_q) : fl_wr_q;
    free_cnt_d = free_cnt_q;
    if (fl_push && !wr_fire)      free_cnt_d = free_cnt_q + CW'(1);
    else if (wr_fire && !fl_push) free_cnt_d = free_cnt_q - CW'(1);

    for (int q = 0; q < QUEUE_NUB; q++) begin
      head_d[q] = head_q[q];
      tail_d[q] = tail_q[q];
      cnt_d[q]  = cnt_q[q];
      if (wr_hit[q]) begin
        tail_d[q] = wr_addr;
        if (cnt_q[q] == '0) head_d[q] = wr_addr;
      end
      if (rd_hit[q]) begin
        // With a single cell left its successor is the cell being linked right now.
        if (wr_hit[q] && (cnt_q[q] == CW'(1))) head_d[q] = wr_addr;
        else                                   head_d[q] = nxt_mem[head_q[q]];
      end
      if (wr_hit[q] && !rd_hit[q])      cnt_d[q] = cnt_q[q] + CW'(1);
      else if (rd_hit[q] && !wr_hit[q]) cnt_d[q] = cnt_q[q] - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          init_cnt_q <= init_cnt_q + AW'(1);
          if (init_cnt_q == AW'(DEPTH - 1)) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
          end
        end
        RUN: init_done_q <= 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fl_rd_q    <= '0;
      fl_wr_q    <= '0;
      free_cnt_q <= '0;
      rd_valid_q <= 1'b0;
      for (int q = 0; q < QUEUE_NUB; q++) begin
        head_q[q] <= '0;
        tail_q[q] <= '0;
        cnt_q[q]  <= '0;
      end
    end else begin
      fl_rd_q    <= fl_rd_d;
      fl_wr_q    <= fl_wr_d;
      free_cnt_q <= free_cnt_d;
      rd_valid_q <= rd_ack;
      for (int q = 0; q < QUEUE_NUB; q++) begin
        head_q[q] <= head_d[q];
        tail_q[q] <= tail_d[q];
        cnt_q[q]  <= cnt_d[q];
      end
    end
  end

  // Pointer arrays carry no reset; the free list is rebuilt during INIT.
  always_ff @(posedge clk) begin
    if (fl_push) fl_mem[fl_wr_q] <= fl_push_addr;
    if (wr_fire && (cnt_q[wr_client] != '0)) nxt_mem[tail_q[wr_client]] <= wr_addr;
  end

  voq_ll_buf_ram #(
    .DW    (DATA_WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_fire),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_en_i   (rd_ack),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  for (genvar q = 0; q < QUEUE_NUB; q++) begin : g_q
    assign queue_empty[q]        = (cnt_q[q] == '0);
    assign queue_cnt[q*CW +: CW] = cnt_q[q];
  end

  assign free_cnt  = free_cnt_q;
  assign init_done = init_done_q;
  assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_voq_ll_buf.sv
// Randomized and directed bench for voq_ll_buf against a per-queue payload model.
module tb_voq_ll_buf;

  localparam int DW    = 128;
  localparam int DEPTH = 64;
  localparam int QN    = 4;
  localparam int QUOTA = 32;
  localparam int QW    = 2;
  localparam int CW    = 7;

  logic          clk;
  logic          rst_n;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic [QW-1:0] wr_client;
  logic          rd_req;
  logic [QW-1:0] rd_client;
  logic          rd_ack;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [QN-1:0] queue_empty;
  logic [QN*CW-1:0] queue_cnt;
  logic [CW-1:0] free_cnt;
  logic          init_done;

  int n_checks;
  int n_err;

  logic [DW-1:0] mdl [QN][$];
  logic [DW-1:0] last_rd;
  bit            m_run;

  voq_ll_buf #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .QUEUE_NUB  (QN),
    .QUOTA      (QUOTA)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .wr_client   (wr_client),
    .rd_req      (rd_req),
    .rd_client   (rd_client),
    .rd_ack      (rd_ack),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .queue_empty (queue_empty),
    .queue_cnt   (queue_cnt),
    .free_cnt    (free_cnt),
    .init_done   (init_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int m_total();
    int t;
    t = 0;
    for (int q = 0; q < QN; q++) t += mdl[q].size();
    return t;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [CW-1:0] qcnt(input int q);
    return queue_cnt[q*CW +: CW];
  endfunction

  // One clock of stimulus: returns what the DUT offered and what the model says it should offer.
  task automatic do_cycle(input bit wv, input int wc, input logic [DW-1:0] wd,
                          input bit rq, input int rc,
                          output logic got_wr, output bit exp_wr,
                          output logic got_ack, output bit exp_ack);
    @(negedge clk);
    wr_valid  = wv;
    wr_client = QW'(wc);
    wr_data   = wd;
    rd_req    = rq;
    rd_client = QW'(rc);
    #1;
    got_wr  = wr_ready;
    got_ack = rd_ack;
    exp_wr  = m_run && (m_total() < DEPTH) && (mdl[wc].size() < QUOTA);
    exp_ack = m_run && rq && (mdl[rc].size() != 0);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    rd_req   = 1'b0;
    if (exp_ack)       last_rd = mdl[rc].pop_front();
    if (wv && exp_wr)  mdl[wc].push_back(wd);
  endtask

  // Releases reset and counts clocks until init_done, probing rd_ack all the while.
  task automatic run_init(output int cyc, output bit ack_seen);
    cyc      = 0;
    ack_seen = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do begin
      rd_req    = 1'b1;
      rd_client = QW'($urandom_range(0, QN - 1));
      #1;
      if (rd_ack !== 1'b0) ack_seen = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
      rd_req = 1'b0;
      if (init_done !== 1'b1) @(negedge clk);
    end while (init_done !== 1'b1 && cyc < 200);
    m_run = (init_done === 1'b1);
  endtask

  task automatic test_reset();
    int cyc;
    bit ack_seen;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    wr_valid = 1'b1; wr_client = 2'd1; rd_req = 1'b1; rd_client = 2'd2;
    #1;
    n_checks++; if (init_done !== 1'b0) begin n_err++; $display("FAIL reset_init_done got=%b exp=0", init_done); end
    n_checks++; if (free_cnt !== 7'd0) begin n_err++; $display("FAIL reset_free_cnt got=%0d exp=0", free_cnt); end
    n_checks++; if (queue_empty !== 4'hF) begin n_err++; $display("FAIL reset_queue_empty got=%b exp=1111", queue_empty); end
    n_checks++; if (queue_cnt !== '0) begin n_err++; $display("FAIL reset_queue_cnt got=%h exp=0", queue_cnt); end
    n_checks++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL reset_wr_ready got=%b exp=0", wr_ready); end
    n_checks++; if (rd_ack !== 1'b0) begin n_err++; $display("FAIL reset_rd_ack got=%b exp=0", rd_ack); end
    n_checks++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    n_checks++; if (rd_data !== '0) begin n_err++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    wr_valid = 1'b0; rd_req = 1'b0;
    run_init(cyc, ack_seen);
    n_checks++; if (cyc != DEPTH) begin n_err++; $display("FAIL init_cycles got=%0d exp=%0d", cyc, DEPTH); end
    n_checks++; if (ack_seen) begin n_err++; $display("FAIL init_rd_ack got=1 exp=0"); end
    n_checks++; if (free_cnt !== 7'd64) begin n_err++; $display("FAIL init_free_cnt got=%0d exp=64", free_cnt); end
    n_checks++; if (queue_empty !== 4'hF) begin n_err++; $display("FAIL init_queue_empty got=%b exp=1111", queue_empty); end
  endtask

  task automatic test_fifo_q2();
    logic gw, ga;
    bit ew, ea;
    logic [DW-1:0] pat [3];
    pat[0] = 128'hA1; pat[1] = 128'hA2; pat[2] = 128'hA3;
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b1, 2, pat[i], 1'b0, 0, gw, ew, ga, ea);
      n_checks++; if (gw !== 1'b1) begin n_err++; $display("FAIL q2_wr_accept%0d got=%b exp=1", i, gw); end
    end
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b0, 0, '0, 1'b1, 2, gw, ew, ga, ea);
      n_checks++; if (ga !== 1'b1) begin n_err++; $display("FAIL q2_rd_ack%0d got=%b exp=1", i, ga); end
      n_checks++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL q2_rd_valid%0d got=%b exp=1", i, rd_valid); end
      n_checks++; if (rd_data !== pat[i]) begin n_err++; $display("FAIL q2_rd_data%0d got=%h exp=%h", i, rd_data, pat[i]); end
    end
    do_cycle(1'b0, 0, '0, 1'b0, 0, gw, ew, ga, ea);
    n_checks++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL q2_rd_valid_drop got=%b exp=0", rd_valid); end
    n_checks++; if (rd_data !== 128'hA3) begin n_err++; $display("FAIL q2_rd_data_hold got=%h exp=a3", rd_data); end
    n_checks++; if (qcnt(2) !== 7'd0) begin n_err++; $display("FAIL q2_cnt got=%0d exp=0", qcnt(2)); end
  endtask

  task automatic test_rd_empty_wr();
    logic gw, ga;
    bit ew, ea;
    do_cycle(1'b1, 3, 128'h33, 1'b1, 3, gw, ew, ga, ea);
    n_checks++; if (ga !== 1'b0) begin n_err++; $display("FAIL empty_rd_ack got=%b exp=0", ga); end
    n_checks++; if (gw !== 1'b1) begin n_err++; $display("FAIL empty_wr_accept got=%b exp=1", gw); end
    n_checks++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL empty_rd_valid got=%b exp=0", rd_valid); end
    do_cycle(1'b0, 0, '0, 1'b1, 3, gw, ew, ga, ea);
    n_checks++; if (rd_data !== 128'h33) begin n_err++; $display("FAIL empty_followup_data got=%h exp=33", rd_data); end
  endtask

  task automatic test_same_q();
    logic gw, ga;
    bit ew, ea;
    do_cycle(1'b1, 1, 128'h11, 1'b0, 0, gw, ew, ga, ea);
    do_cycle(1'b1, 1, 128'h22, 1'b1, 1, gw, ew, ga, ea);
    n_checks++; if (ga !== 1'b1) begin n_err++; $display("FAIL sameq_rd_ack got=%b exp=1", ga); end
    n_checks++; if (gw !== 1'b1) begin n_err++; $display("FAIL sameq_wr_accept got=%b exp=1", gw); end
    n_checks++; if (rd_data !== 128'h11) begin n_err++; $display("FAIL sameq_rd_data got=%h exp=11", rd_data); end
    n_checks++; if (qcnt(1) !== 7'd1) begin n_err++; $display("FAIL sameq_cnt got=%0d exp=1", qcnt(1)); end
    do_cycle(1'b0, 0, '0, 1'b1, 1, gw, ew, ga, ea);
    n_checks++; if (rd_data !== 128'h22) begin n_err++; $display("FAIL sameq_next_data got=%h exp=22", rd_data); end
    n_checks++; if (qcnt(1) !== 7'd0) begin n_err++; $display("FAIL sameq_cnt_end got=%0d exp=0", qcnt(1)); end
  endtask

  task automatic test_quota();
    logic gw, ga;
    bit ew, ea;
    int acc;
    acc = 0;
    for (int i = 0; i < QUOTA; i++) begin
      do_cycle(1'b1, 0, rnd_data(), 1'b0, 0, gw, ew, ga, ea);
      if (gw === 1'b1) acc++;
    end
    n_checks++; if (acc != QUOTA) begin n_err++; $display("FAIL quota_accepted got=%0d exp=%0d", acc, QUOTA); end
    n_checks++; if (qcnt(0) !== 7'd32) begin n_err++; $display("FAIL quota_cnt got=%0d exp=32", qcnt(0)); end
    do_cycle(1'b0, 0, '0, 1'b0, 0, gw, ew, ga, ea);
    n_checks++; if (gw !== 1'b0) begin n_err++; $display("FAIL quota_wr_ready_q0 got=%b exp=0", gw); end
    do_cycle(1'b0, 1, '0, 1'b0, 0, gw, ew, ga, ea);
    n_checks++; if (gw !== 1'b1) begin n_err++; $display("FAIL quota_wr_ready_q1 got=%b exp=1", gw); end
  endtask

  task automatic test_full();
    logic gw, ga;
    bit ew, ea;
    for (int i = 0; i < QUOTA; i++) do_cycle(1'b1, 1, rnd_data(), 1'b0, 0, gw, ew, ga, ea);
    n_checks++; if (free_cnt !== 7'd0) begin n_err++; $display("FAIL full_free_cnt got=%0d exp=0", free_cnt); end
    do_cycle(1'b0, 3, '0, 1'b0, 0, gw, ew, ga, ea);
    n_checks++; if (gw !== 1'b0) begin n_err++; $display("FAIL full_wr_ready got=%b exp=0", gw); end
    do_cycle(1'b1, 3, 128'h3A, 1'b1, 0, gw, ew, ga, ea);
    n_checks++; if (ga !== 1'b1) begin n_err++; $display("FAIL full_rd_ack got=%b exp=1", ga); end
    n_checks++; if (gw !== 1'b0) begin n_err++; $display("FAIL full_same_cycle_wr got=%b exp=0", gw); end
    n_checks++; if (rd_data !== last_rd) begin n_err++; $display("FAIL full_rd_data got=%h exp=%h", rd_data, last_rd); end
    do_cycle(1'b1, 3, 128'h3A, 1'b0, 0, gw, ew, ga, ea);
    n_checks++; if (gw !== 1'b1) begin n_err++; $display("FAIL full_next_cycle_wr got=%b exp=1", gw); end
    n_checks++; if (qcnt(3) !== 7'd1) begin n_err++; $display("FAIL full_q3_cnt got=%0d exp=1", qcnt(3)); end
  endtask

  task automatic drain_all();
    logic gw, ga;
    bit ew, ea;
    int guard;
    for (int q = 0; q < QN; q++) begin
      guard = 0;
      while (mdl[q].size() != 0 && guard < 100) begin
        do_cycle(1'b0, 0, '0, 1'b1, q, gw, ew, ga, ea);
        guard++;
        n_checks++; if (ga !== 1'b1) begin n_err++; $display("FAIL drain_rd_ack q=%0d got=%b exp=1", q, ga); end
        n_checks++; if (rd_data !== last_rd) begin n_err++; $display("FAIL drain_rd_data q=%0d got=%h exp=%h", q, rd_data, last_rd); end
      end
    end
    n_checks++; if (free_cnt !== 7'd64) begin n_err++; $display("FAIL drain_free_cnt got=%0d exp=64", free_cnt); end
    n_checks++; if (queue_empty !== 4'hF) begin n_err++; $display("FAIL drain_queue_empty got=%b exp=1111", queue_empty); end
  endtask

  task automatic test_random();
    logic gw, ga;
    bit ew, ea, wv, rq;
    int wp, rp, wc, rc;
    for (int i = 0; i < 900; i++) begin
      wp = (i < 300) ? 90 : (i < 600) ? 50 : 15;
      rp = (i < 300) ? 20 : (i < 600) ? 50 : 90;
      wv = ($urandom_range(0, 99) < wp);
      rq = ($urandom_range(0, 99) < rp);
      wc = $urandom_range(0, QN - 1);
      rc = $urandom_range(0, QN - 1);
      do_cycle(wv, wc, rnd_data(), rq, rc, gw, ew, ga, ea);
      n_checks++; if (gw !== ew) begin n_err++; $display("FAIL rnd_wr_ready cyc=%0d got=%b exp=%b", i, gw, ew); end
      n_checks++; if (ga !== ea) begin n_err++; $display("FAIL rnd_rd_ack cyc=%0d got=%b exp=%b", i, ga, ea); end
      n_checks++; if (rd_valid !== ea) begin n_err++; $display("FAIL rnd_rd_valid cyc=%0d got=%b exp=%b", i, rd_valid, ea); end
      n_checks++; if (rd_data !== last_rd) begin n_err++; $display("FAIL rnd_rd_data cyc=%0d got=%h exp=%h", i, rd_data, last_rd); end
      if (i % 8 == 0) begin
        for (int q = 0; q < QN; q++) begin
          n_checks++; if (qcnt(q) !== CW'(mdl[q].size())) begin n_err++; $display("FAIL rnd_queue_cnt cyc=%0d q=%0d got=%0d exp=%0d", i, q, qcnt(q), mdl[q].size()); end
        end
        n_checks++; if (free_cnt !== CW'(DEPTH - m_total())) begin n_err++; $display("FAIL rnd_free_cnt cyc=%0d got=%0d exp=%0d", i, free_cnt, DEPTH - m_total()); end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic gw, ga;
    bit ew, ea, ack_seen;
    int cyc;
    for (int i = 0; i < 10; i++) begin
      do_cycle(1'b1, i % QN, rnd_data(), 1'b0, 0, gw, ew, ga, ea);
      n_checks++; if (gw !== 1'b1) begin n_err++; $display("FAIL mrst_fill%0d got=%b exp=1", i, gw); end
    end
    n_checks++; if (free_cnt !== 7'd54) begin n_err++; $display("FAIL mrst_pre_free got=%0d exp=54", free_cnt); end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    for (int q = 0; q < QN; q++) mdl[q].delete();
    last_rd = '0;
    m_run   = 1'b0;
    n_checks++; if (queue_empty !== 4'hF) begin n_err++; $display("FAIL mrst_queue_empty got=%b exp=1111", queue_empty); end
    n_checks++; if (init_done !== 1'b0) begin n_err++; $display("FAIL mrst_init_done got=%b exp=0", init_done); end
    n_checks++; if (rd_data !== '0) begin n_err++; $display("FAIL mrst_rd_data got=%h exp=0", rd_data); end
    run_init(cyc, ack_seen);
    n_checks++; if (cyc != DEPTH) begin n_err++; $display("FAIL mrst_init_cycles got=%0d exp=%0d", cyc, DEPTH); end
    n_checks++; if (ack_seen) begin n_err++; $display("FAIL mrst_rd_ack_during_init got=1 exp=0"); end
    n_checks++; if (free_cnt !== 7'd64) begin n_err++; $display("FAIL mrst_free_cnt got=%0d exp=64", free_cnt); end
    for (int q = 0; q < QN; q++) begin
      do_cycle(1'b0, 0, '0, 1'b1, q, gw, ew, ga, ea);
      n_checks++; if (ga !== 1'b0) begin n_err++; $display("FAIL mrst_rd_ack q=%0d got=%b exp=0", q, ga); end
    end
    do_cycle(1'b1, 2, 128'h5A, 1'b0, 0, gw, ew, ga, ea);
    do_cycle(1'b0, 0, '0, 1'b1, 2, gw, ew, ga, ea);
    n_checks++; if (rd_data !== 128'h5A) begin n_err++; $display("FAIL mrst_recover_data got=%h exp=5a", rd_data); end
  endtask

  initial begin
    n_checks  = 0;
    n_err     = 0;
    last_rd   = '0;
    m_run     = 1'b0;
    rst_n     = 1'b0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    wr_client = '0;
    rd_req    = 1'b0;
    rd_client = '0;

    test_reset();
    test_fifo_q2();
    test_rd_empty_wr();
    test_same_q();
    test_quota();
    test_full();
    drain_all();
    test_random();
    drain_all();
    test_mid_reset();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/voq_ll_buf.md
VOQ_LL_BUF -- requirements
Module: voq_ll_buf

Interface
REQ-001 The block SHALL expose parameters, one per line:
- DATA_WIDTH, 128, cell payload width.
- DEPTH, 64, shared cells, >=2.
- QUEUE_NUB, 4, output queues, >=2.
- QUOTA, 32, max cells any one queue may hold, 1..DEPTH.
REQ-002 The block SHALL derive AW=$clog2(DEPTH), QW=$clog2(QUEUE_NUB), CW=AW+1.
REQ-003 The block SHALL expose ports, one per line:
- clk, in, 1, sole clock, rising edge.
- rst_n, in, 1, synchronous active-low reset.
- wr_valid, in, 1, write cell offered.
- wr_ready, out, 1, write cell can be accepted.
- wr_data, in, DATA_WIDTH, write payload.
- wr_client, in, QW, destination queue.
- rd_req, in, 1, dequeue request.
- rd_client, in, QW, queue to dequeue.
- rd_ack, out, 1, rd_req accepted this cycle (combinational).
- rd_valid, out, 1, rd_data valid.
- rd_data, out, DATA_WIDTH, dequeued payload.
- queue_empty, out, QUEUE_NUB, per-queue empty flags.
- queue_cnt, out, QUEUE_NUB*CW, per-queue occupancy; queue i at bits [i*CW +: CW].
- free_cnt, out, CW, free cells.
- init_done, out, 1, free list initialised.

Function
REQ-004 Queues SHALL be linked lists in one shared cell store: per-queue head/tail/count registers, DEPTH x AW next-pointer array, FIFO free list of DEPTH entries.
REQ-005 FSM SHALL have states INIT, RUN; INIT pushes addresses 0..DEPTH-1, one per cycle, then enters RUN; init_done=1 only in RUN.
REQ-006 wr_ready SHALL be 1 only when: RUN, free_cnt>0, wr_client<QUEUE_NUB, queue_cnt[wr_client]<QUOTA; computed from registered state only.
REQ-007 A write SHALL be accepted on wr_valid&&wr_ready: pop free-list head A, store wr_data at A, link A after tail (or set head=A if empty), tail=A, count+1.
REQ-008 rd_ack SHALL equal rd_req && RUN && rd_client<QUEUE_NUB && !queue_empty[rd_client].
REQ-009 On rd_ack: read cell at head H, head=next[H], count-1, push H to free list.
REQ-010 rd_valid SHALL pulse exactly one cycle after rd_ack; rd_data SHALL hold the last dequeued payload until the next rd_valid.
REQ-011 Accepting write and read in one cycle SHALL be supported for any queue pair; free_cnt net change is 0.
REQ-012 Write and read in one cycle to the same queue with count==1 SHALL set head=tail=new address and leave count at 1.
REQ-013 A read to an empty queue SHALL not ack even if a write to that queue is accepted in the same cycle.
REQ-014 A cell freed in cycle N SHALL not make wr_ready high before cycle N+1.
REQ-015 Counters SHALL be CW bits wide and never wrap; queue_cnt and free_cnt sum to DEPTH in RUN.
REQ-016 Cell ordering within a queue SHALL be strict FIFO; queues are mutually independent.

Reset
REQ-017 With rst_n=0 at a clk edge, the block SHALL enter INIT and set these values:
- all counts, heads and tails 0;
- queue_empty all 1;
- free_cnt, wr_ready, rd_ack, rd_valid, init_done 0;
- rd_data 0.
REQ-018 Reset mid-operation SHALL discard all queued cells and re-run INIT (DEPTH cycles).

Structure
REQ-019 Package voq_pkg SHALL hold the FSM state enum (INIT, RUN) and the CW/AW width helper functions.
REQ-020 Payload storage SHALL use the team's existing dual-port ram sub-module (registered read); the next-pointer array and free list SHALL stay inside voq_ll_buf.

Verification
REQ-021 Release reset; bench SHALL see init_done rise after exactly 64 cycles, then free_cnt=64 and queue_empty=4'b1111.
REQ-022 Write 0xA1,0xA2,0xA3 to q2, then read q2 three times; bench SHALL see rd_data A1,A2,A3, one cycle after each rd_ack, and queue_cnt[q2]=0.
REQ-023 Write 32 cells to q0; bench SHALL see wr_ready=0 for wr_client=0 at the 33rd cell and wr_ready=1 for wr_client=1.
REQ-024 Fill q0..q1 to 32 each (free_cnt=0); bench SHALL see wr_ready=0; one read q0 plus a same-cycle write to q3 SHALL leave the write unaccepted, and the write SHALL be accepted next cycle.
REQ-025 With q1 holding one cell 0x11, write 0x22 to q1 and read q1 in the same cycle; bench SHALL see rd_data=0x11, queue_cnt[q1]=1, and the next read returns 0x22.
REQ-026 Assert rst_n=0 for one cycle with 10 cells queued; bench SHALL see all queues empty and no rd_ack for 64 cycles.
